// File: rtl/mem_store_buffer_pkg.sv
// rtl/mem_store_buffer_pkg.sv - shared types for the store buffer (package mem_pkg)
package mem_pkg;
  localparam int WORD_BYTES = 4;
  localparam int ENTRY_AW   = 32;
  localparam int ENTRY_DW   = 32;

  typedef struct packed {
    logic [ENTRY_AW-1:0] addr;
    logic [ENTRY_DW-1:0] data;
  } sb_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } sb_state_t;
endpackage

// File: rtl/sb_match.sv
// rtl/sb_match.sv - per-entry exact/overlap compare against a load address
// with youngest-exact-hit select
module sb_match
  import mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int PW    = 2,
  parameter int CW    = 3
) (
  input  logic [AW-1:0] i_ld_addr,
  input  logic [AW-1:0] i_addr [DEPTH],
  input  logic [PW-1:0] i_head,
  input  logic [CW-1:0] i_count,
  output logic          o_exact,
  output logic          o_overlap,
  output logic [PW-1:0] o_hit_idx
);
  always_comb begin
    logic [PW-1:0] idx;
    logic [AW-1:0] diff;
    idx       = '0;
    diff      = '0;
    o_exact   = 1'b0;
    o_overlap = 1'b0;
    o_hit_idx = i_head;
    // Walk oldest to youngest so the last exact hit wins.
    for (int k = 0; k < DEPTH; k++) begin
      idx  = i_head + PW'(k);
      diff = i_ld_addr - i_addr[idx];
      if (CW'(k) < i_count) begin
        if (diff == '0) begin
          o_exact   = 1'b1;
          o_hit_idx = idx;
        end else if (diff + AW'(WORD_BYTES - 1) < AW'(2 * WORD_BYTES - 1)) begin
          o_overlap = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/mem_store_buffer.sv
// rtl/mem_store_buffer.sv - in-order store buffer in front of a single-port data memory
// STORE_BUF_FWD_EN: forward exact-hit store data to loads instead of stalling
module mem_store_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = ENTRY_AW,
  parameter int DW    = ENTRY_DW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_st_valid,
  input  logic [AW-1:0] i_st_addr,
  input  logic [DW-1:0] i_st_data,
  input  logic          i_ld_req,
  input  logic [AW-1:0] i_ld_addr,
  input  logic          i_fence,
  input  logic          i_mem_busy,
  input  logic [DW-1:0] i_mem_rd,
  output logic          o_stall,
  output logic [DW-1:0] o_ld_data,
  output logic          o_fence_done,
  output logic          o_mem_read,
  output logic          o_mem_write,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wd
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t r_entries [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  sb_state_t     r_state;
  logic          r_fence_done;
  logic          r_done_sent;

  logic [AW-1:0] w_addrs [DEPTH];
  logic          w_exact;
  logic          w_overlap;
  logic [PW-1:0] w_hit_idx;
  logic          w_full;
  logic          w_run;
  logic          w_conflict;
  logic          w_ld_blocked;
  logic          w_ld_go;
  logic          w_drain;
  logic          w_push;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) w_addrs[i] = r_entries[i].addr;
  end

  sb_match #(.DEPTH(DEPTH), .AW(AW), .PW(PW), .CW(CW)) u_match (
    .i_ld_addr (i_ld_addr),
    .i_addr    (w_addrs),
    .i_head    (r_head),
    .i_count   (r_count),
    .o_exact   (w_exact),
    .o_overlap (w_overlap),
    .o_hit_idx (w_hit_idx)
  );

`ifdef STORE_BUF_FWD_EN
  assign w_conflict = w_overlap;
  assign o_ld_data  = w_exact ? r_entries[w_hit_idx].data : i_mem_rd;
`else
  assign w_conflict = w_overlap | w_exact;
  assign o_ld_data  = i_mem_rd;
`endif

  assign w_full       = (r_count == CW'(DEPTH));
  assign w_run        = (r_state == RUN);
  assign w_ld_blocked = !w_run || i_fence || w_conflict;
  // A blocked load releases the port so the entries it waits on can drain.
  assign w_ld_go      = !i_rst && i_ld_req && !w_ld_blocked;
  assign w_drain      = !i_rst && !w_ld_go && !i_mem_busy && (r_count != '0);
  assign w_push       = !i_rst && i_st_valid && !w_full && w_run;

  assign o_stall      = (i_ld_req && w_ld_blocked) || (i_st_valid && (w_full || !w_run));
  assign o_mem_read   = w_ld_go;
  assign o_mem_write  = w_drain;
  assign o_mem_addr   = w_ld_go ? i_ld_addr : (w_drain ? r_entries[r_head].addr : '0);
  assign o_mem_wd     = w_drain ? r_entries[r_head].data : '0;
  assign o_fence_done = r_fence_done;

  always_ff @(posedge i_clk) begin
    if (w_push) r_entries[r_tail] <= '{addr: i_st_addr, data: i_st_data};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_state      <= RUN;
      r_fence_done <= 1'b0;
      r_done_sent  <= 1'b0;
    end else begin
      if (w_push)  r_tail <= r_tail + PW'(1);
      if (w_drain) r_head <= r_head + PW'(1);
      r_count      <= r_count + CW'(w_push) - CW'(w_drain);
      r_fence_done <= 1'b0;
      case (r_state)
        RUN: begin
          if (i_fence) begin
            r_state     <= FLUSH;
            r_done_sent <= 1'b0;
          end
        end
        FLUSH: begin
          if (r_count == '0) begin
            if (!r_done_sent) begin
              r_fence_done <= 1'b1;
              r_done_sent  <= 1'b1;
            end
            if (!i_fence) r_state <= RUN;
          end
        end
      endcase
    end
  end
endmodule
